phase_row_sender: RTL

Upstream feeder for the phase-matching core. For every image row it reads a phase2 row and a phase1 row from row memory and emits them as two AXI-Stream packets: phase2 first, which the core routes to its cache, then phase1, which the core routes to its phase FIFO. It honours the core's two-packet admission limit by withholding the next row pair until the core's disparity packet for the current row has been delivered. It reports frame completion and protocol errors.

---
 rtl/phase_row_sender.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/phase_row_sender.sv
// Row-pair feeder for the phase-matching core.
// Each image row is read from row memory twice: the phase2 row first, then the phase1 row.
// Both rows go out as AXI-Stream packets through a 2-entry skid FIFO. The next row pair
// is held back until the core's disparity packet for the current row has been seen.
module phase_row_sender #(
  parameter int unsigned ROW_SIZE   = 1280,
  parameter int unsigned BEAT_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_NUM    = 1024,
  localparam int unsigned BPR       = ROW_SIZE / BEAT_SIZE,
  localparam int unsigned AW        = $clog2(ROW_NUM * BPR)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            mem_rd_en,
  output logic                            mem_rd_sel,
  output logic [AW-1:0]                   mem_rd_addr,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] mem_rd_data,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            res_tvalid,
  input  logic                            res_tready,
  input  logic                            res_tlast
);

  localparam int unsigned DW = BEAT_SIZE * DATA_WIDTH;
  localparam int unsigned RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int unsigned BW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int unsigned CW = $clog2(2 * BPR);

  typedef enum logic [2:0] {
    StIdle,
    StRdP2,
    StRdP1,
    StDrain,
    StWaitRes,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q;
  logic [BW-1:0]   rd_beat_q;
  logic [CW-1:0]   out_cnt_q;
  logic            err_q;

  // Skid FIFO and the one read that may be in flight from row memory
  logic            inflight_q;
  logic [DW-1:0]   fifo_mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      fifo_cnt_q;

  logic            res_last_hs;
  logic            pop;
  logic            start_acc;
  logic            rd_en;
  logic            row_inc;
  logic            err_set;
  logic            last_rd;
  logic            last_out;
  logic            has_room;
  logic [2:0]      fill_after;

  assign res_last_hs = res_tvalid & res_tready & res_tlast;
  assign pop         = (fifo_cnt_q != 2'd0) & m_axis_tready;
  assign last_rd     = (rd_beat_q == BW'(BPR - 1));
  assign last_out    = (out_cnt_q == CW'(2 * BPR - 1));

  // Occupancy is taken after this cycle's pop so a steady 1 beat/cycle flow is sustained;
  // the FIFO still never holds more than two entries once the in-flight read lands.
  assign fill_after  = 3'(fifo_cnt_q) - 3'(pop) + 3'(inflight_q);
  assign has_room    = (fill_after < 3'd2);

  // Next-state decode and per-state strobes
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    row_inc   = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = StRdP2;
        end
      end
      StRdP2: begin
        rd_en = has_room;
        if (has_room && last_rd) begin
          state_d = StRdP1;
        end
      end
      StRdP1: begin
        rd_en = has_room;
        if (has_room && last_rd) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && last_out) begin
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        if (res_last_hs) begin
          row_inc = 1'b1;
          state_d = (row_q == RW'(ROW_NUM - 1)) ? StDone : StRdP2;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A result packet ending anywhere but WAIT_RES is a protocol error
  assign err_set = res_last_hs & (state_q != StWaitRes);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Row, read-beat and output-beat counters plus the sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      rd_beat_q <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start_acc) begin
        row_q     <= '0;
        rd_beat_q <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_en) begin
          rd_beat_q <= last_rd ? '0 : rd_beat_q + BW'(1);
        end
        if (row_inc) begin
          row_q <= row_q + RW'(1);
        end
        if (pop) begin
          out_cnt_q <= last_out ? '0 : out_cnt_q + CW'(1);
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (start_acc) begin
        err_q <= 1'b0;
      end
    end
  end

  // FIFO control; clearing inflight_q on reset drops any read still returning
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

  // FIFO storage; contents are don't-care while empty because tdata is gated by tvalid
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_mem_q[wr_ptr_q] <= mem_rd_data;
    end
  end

  assign busy          = (state_q != StIdle);
  assign err           = err_q;
  assign mem_rd_en     = rd_en;
  assign mem_rd_sel    = (state_q == StRdP2);
  assign mem_rd_addr   = ((state_q == StRdP2) || (state_q == StRdP1)) ?
                         AW'(row_q) * AW'(BPR) + AW'(rd_beat_q) : '0;

  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid &
                         ((out_cnt_q == CW'(BPR - 1)) | last_out);

endmodule
